// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port arbiter.
package cpu_mem_pkg;

  localparam int unsigned DATA_W = 28;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned MEM_AW = 8;

  // Requester indices.
  localparam int unsigned P_FETCH = 0;
  localparam int unsigned P_LSU   = 1;

  // Access sequencing: accept -> drive memory -> report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the current requests and the previous winner.
  always_comb begin
    gnt_o = '0;
    if (req_i[0] && (!req_i[1] || last_i)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between instruction fetch (port 0)
// and the load/store unit (port 1). One access in flight; a new request can
// be accepted in the response cycle of the previous one.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_mem_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int unsigned MEM_AW = cpu_mem_pkg::MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);

  state_e            state_q, state_d;
  logic              last_q;
  logic              port_q;
  logic              we_q;
  logic              oor_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_in_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;

  logic [1:0]        req;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              accept;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  assign req = {p1_req, p0_req};

  rr_arb2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Next state, grant and memory write enable.
  always_comb begin
    state_d = state_q;
    gnt     = '0;
    accept  = 1'b0;
    winner  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (!rst && (arb_gnt != 2'b00)) begin
          gnt     = arb_gnt;
          accept  = 1'b1;
          winner  = arb_gnt[1];
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Out-of-range writes are suppressed so they never alias into memory.
        mem_we  = we_q && !oor_q;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mux the winning requester's command.
  always_comb begin
    sel_we    = winner ? p1_we    : p0_we;
    sel_addr  = winner ? p1_addr  : p0_addr;
    sel_wdata = winner ? p1_wdata : p0_wdata;
    sel_oor   = |sel_addr[ADDR_W-1:MEM_AW];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, memory drive registers and the response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      // Memory address/data are loaded on accept so they are valid for the
      // whole ACCESS cycle and simply hold afterwards.
      if (accept) begin
        last_q     <= winner;
        port_q     <= winner;
        we_q       <= sel_we;
        oor_q      <= sel_oor;
        mem_addr_q <= {{(ADDR_W-MEM_AW){1'b0}}, sel_addr[MEM_AW-1:0]};
        mem_in_q   <= sel_wdata;
      end
      if (state_q == ACCESS) begin
        done_q[port_q] <= 1'b1;
        err_q[port_q]  <= oor_q;
        if (!we_q) begin
          rdata_q <= oor_q ? '0 : mem_out;
        end
      end
    end
  end

  assign p0_gnt   = gnt[P_FETCH];
  assign p1_gnt   = gnt[P_LSU];
  assign p0_done  = done_q[P_FETCH];
  assign p1_done  = done_q[P_LSU];
  assign p0_err   = err_q[P_FETCH];
  assign p1_err   = err_q[P_LSU];
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;

endmodule
